// File: rtl/csr_regfile.sv
// Machine-mode CSR register file: single-cycle CSR access with a registered response,
// trap/mret bookkeeping for mstatus/mepc/mcause/mtval, and 64-bit cycle/instret counters.
module csr_regfile #(
    parameter logic [31:0] HART_ID    = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req_valid,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic        csr_rsp_valid,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        instr_retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        mie_o
);
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic        rsp_valid_q, rsp_valid_d, illegal_q, illegal_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] rd_val, new_val;
    logic        legal, read_only, wr_en;

    always_comb begin
        rd_val    = 32'h0;
        legal     = 1'b1;
        read_only = 1'b0;
        case (csr_addr)
            12'h300: rd_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            12'h301: begin rd_val = MISA_VALUE; read_only = 1'b1; end
            12'h305: rd_val = mtvec_q;
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = mepc_q;
            12'h342: rd_val = mcause_q;
            12'h343: rd_val = mtval_q;
            12'hB00: rd_val = mcycle_q[31:0];
            12'hB80: rd_val = mcycle_q[63:32];
            12'hB02: rd_val = minstret_q[31:0];
            12'hB82: rd_val = minstret_q[63:32];
            12'hC00: begin rd_val = mcycle_q[31:0]; read_only = 1'b1; end
            12'hF14: begin rd_val = HART_ID; read_only = 1'b1; end
            default: legal = 1'b0;
        endcase

        case (csr_op)
            OP_WRITE: new_val = csr_wdata;
            OP_SET:   new_val = rd_val | csr_wdata;
            OP_CLEAR: new_val = rd_val & ~csr_wdata;
            default:  new_val = rd_val;
        endcase

        wr_en = csr_req_valid && legal && !read_only && (csr_op != OP_READ);

        rsp_valid_d = csr_req_valid;
        illegal_d   = csr_req_valid && (!legal || (read_only && (csr_op != OP_READ)));
        rdata_d     = (csr_req_valid && legal) ? rd_val : 32'h0;

        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instr_retire};

        if (wr_en) begin
            case (csr_addr)
                12'h300: begin mie_d = new_val[3]; mpie_d = new_val[7]; end
                12'h305: mtvec_d    = {new_val[31:2], 2'b00};
                12'h340: mscratch_d = new_val;
                12'h341: mepc_d     = {new_val[31:1], 1'b0};
                12'h342: mcause_d   = new_val;
                12'h343: mtval_d    = new_val;
                // A half write replaces the increment; the other half holds without carry.
                12'hB00: mcycle_d   = {mcycle_q[63:32], new_val};
                12'hB80: mcycle_d   = {new_val, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], new_val};
                12'hB82: minstret_d = {new_val, minstret_q[31:0]};
                default: ;
            endcase
        end

        // Trap beats mret beats CSR write; counters are not involved.
        if (trap_valid) begin
            mepc_d   = {trap_pc[31:1], 1'b0};
            mcause_d = trap_cause;
            mtval_d  = trap_tval;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_valid) begin
            mie_d    = mpie_q;
            mpie_d   = 1'b1;
            mepc_d   = mepc_q;
            mcause_d = mcause_q;
            mtval_d  = mtval_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            mtvec_q     <= 32'h0;
            mscratch_q  <= 32'h0;
            mepc_q      <= 32'h0;
            mcause_q    <= 32'h0;
            mtval_q     <= 32'h0;
            mcycle_q    <= 64'h0;
            minstret_q  <= 64'h0;
            rsp_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            mie_q       <= mie_d;
            mpie_q      <= mpie_d;
            mtvec_q     <= mtvec_d;
            mscratch_q  <= mscratch_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            mtval_q     <= mtval_d;
            mcycle_q    <= mcycle_d;
            minstret_q  <= minstret_d;
            rsp_valid_q <= rsp_valid_d;
            illegal_q   <= illegal_d;
            rdata_q     <= rdata_d;
        end
    end

    assign csr_rsp_valid = rsp_valid_q;
    assign csr_rdata     = rdata_q;
    assign csr_illegal   = illegal_q;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign mie_o         = mie_q;
endmodule

// File: tb/tb_csr_regfile.sv
// Directed self-checking bench for csr_regfile: CSR ops, mstatus/trap/mret,
// counters, illegal accesses, same-cycle priority and reset behaviour.
module tb_csr_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        csr_req_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_rsp_valid;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instr_retire;
    logic        trap_valid;
    logic [31:0] trap_pc, trap_cause, trap_tval;
    logic        mret_valid;
    logic [31:0] mtvec_o, mepc_o;
    logic        mie_o;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] r_data;
    logic        r_ill, r_vld;

    localparam logic [1:0] RD = 2'd0, WR = 2'd1, ST = 2'd2, CL = 2'd3;

    csr_regfile dut (
        .clk(clk), .rst(rst),
        .csr_req_valid(csr_req_valid), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rsp_valid(csr_rsp_valid), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .instr_retire(instr_retire),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_cause(trap_cause),
        .trap_tval(trap_tval), .mret_valid(mret_valid),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Presents one request now, returns the response sampled 1 ns after the next edge.
    task automatic csr_access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_req_valid = 1'b1;
        csr_op        = op;
        csr_addr      = addr;
        csr_wdata     = wd;
        @(posedge clk);
        #1;
        r_vld = csr_rsp_valid;
        r_data = csr_rdata;
        r_ill = csr_illegal;
        csr_req_valid = 1'b0;
        csr_op        = RD;
        csr_wdata     = 32'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        csr_req_valid = 1'b0; csr_op = RD; csr_addr = 12'h0; csr_wdata = 32'h0;
        instr_retire = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
        trap_pc = 32'h0; trap_cause = 32'h0; trap_tval = 32'h0;
        idle(3);
        check_val("rst_rsp_valid", {31'b0, csr_rsp_valid}, 32'h0);
        check_val("rst_rdata", csr_rdata, 32'h0);
        check_val("rst_illegal", {31'b0, csr_illegal}, 32'h0);
        check_val("rst_mtvec", mtvec_o, 32'h0);
        check_val("rst_mepc", mepc_o, 32'h0);
        check_val("rst_mie", {31'b0, mie_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // mscratch write / set / clear / read, back to back
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEFF);
        exp_q.push_back(32'h0000_BEFF);
        csr_access(WR, 12'h340, 32'hDEAD_BEEF);
        check_val("mscratch_wr", r_data, exp_q.pop_front());
        check_val("mscratch_vld", {31'b0, r_vld}, 32'h1);
        csr_access(ST, 12'h340, 32'h0000_0010);
        check_val("mscratch_set", r_data, exp_q.pop_front());
        csr_access(CL, 12'h340, 32'hDEAD_0000);
        check_val("mscratch_clr", r_data, exp_q.pop_front());
        csr_access(RD, 12'h340, 32'h0);
        check_val("mscratch_rd", r_data, exp_q.pop_front());
        check_val("mscratch_ill", {31'b0, r_ill}, 32'h0);

        // mstatus masking
        csr_access(WR, 12'h300, 32'hFFFF_FFFF);
        check_val("mstatus_old", r_data, 32'h0000_1800);
        csr_access(RD, 12'h300, 32'h0);
        check_val("mstatus_rd", r_data, 32'h0000_1888);
        check_val("mie_o_set", {31'b0, mie_o}, 32'h1);

        // trap then mret
        trap_valid = 1'b1; trap_pc = 32'h8000_0103; trap_cause = 32'h2; trap_tval = 32'h1234_5678;
        idle(1);
        trap_valid = 1'b0;
        check_val("trap_mepc", mepc_o, 32'h8000_0102);
        check_val("trap_mie", {31'b0, mie_o}, 32'h0);
        csr_access(RD, 12'h300, 32'h0);
        check_val("trap_mstatus", r_data, 32'h0000_1880);
        csr_access(RD, 12'h342, 32'h0);
        check_val("trap_mcause", r_data, 32'h0000_0002);
        csr_access(RD, 12'h343, 32'h0);
        check_val("trap_mtval", r_data, 32'h1234_5678);
        mret_valid = 1'b1;
        idle(1);
        mret_valid = 1'b0;
        csr_access(RD, 12'h300, 32'h0);
        check_val("mret_mstatus", r_data, 32'h0000_1888);

        // mtvec low bits forced to zero
        csr_access(WR, 12'h305, 32'h8000_0003);
        csr_access(RD, 12'h305, 32'h0);
        check_val("mtvec_rd", r_data, 32'h8000_0000);
        check_val("mtvec_o", mtvec_o, 32'h8000_0000);

        // mcycle low-half write, carry into high half after wrap
        csr_access(WR, 12'hB80, 32'h0);
        csr_access(WR, 12'hB00, 32'hFFFF_FFFE);
        idle(3);
        csr_access(RD, 12'hB00, 32'h0);
        check_val("mcycle_lo", r_data, 32'h0000_0001);
        csr_access(RD, 12'hB80, 32'h0);
        check_val("mcycle_hi", r_data, 32'h0000_0001);

        // minstret counts only retirements; its write beats that cycle's retire
        instr_retire = 1'b1;
        csr_access(WR, 12'hB02, 32'h0000_0010);
        csr_access(RD, 12'hB02, 32'h0);
        check_val("minstret_wr", r_data, 32'h0000_0010);
        instr_retire = 1'b0;
        idle(2);
        instr_retire = 1'b1;
        idle(2);
        instr_retire = 1'b0;
        csr_access(RD, 12'hB02, 32'h0);
        check_val("minstret_cnt", r_data, 32'h0000_0013);

        // illegal accesses
        csr_access(WR, 12'hC00, 32'h5);
        check_val("cycle_wr_ill", {31'b0, r_ill}, 32'h1);
        csr_access(WR, 12'hF14, 32'h5);
        check_val("hartid_wr_ill", {31'b0, r_ill}, 32'h1);
        csr_access(RD, 12'hF14, 32'h0);
        check_val("hartid_rd", r_data, 32'h0);
        check_val("hartid_rd_ill", {31'b0, r_ill}, 32'h0);
        csr_access(RD, 12'h7C0, 32'h0);
        check_val("unimpl_ill", {31'b0, r_ill}, 32'h1);
        check_val("unimpl_rdata", r_data, 32'h0);
        csr_access(WR, 12'h301, 32'h0);
        check_val("misa_wr_ill", {31'b0, r_ill}, 32'h1);
        csr_access(RD, 12'h301, 32'h0);
        check_val("misa_rd", r_data, 32'h4000_0100);
        csr_access(RD, 12'h340, 32'h0);
        check_val("state_kept", r_data, 32'h0000_BEFF);

        // trap and MEPC write in the same cycle: trap wins, response still issued
        trap_valid = 1'b1; trap_pc = 32'h0000_0201; trap_cause = 32'h7; trap_tval = 32'h0;
        csr_access(WR, 12'h341, 32'h0000_0100);
        trap_valid = 1'b0;
        check_val("prio_mepc", mepc_o, 32'h0000_0200);
        check_val("prio_rsp_vld", {31'b0, r_vld}, 32'h1);

        // reset in the middle of an access drops the response
        @(negedge clk);
        csr_req_valid = 1'b1; csr_op = WR; csr_addr = 12'h340; csr_wdata = 32'h1;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_mid_vld", {31'b0, csr_rsp_valid}, 32'h0);
        csr_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("post_rst_vld", {31'b0, csr_rsp_valid}, 32'h0);
        csr_access(RD, 12'hB00, 32'h0);
        check_val("post_rst_mcycle", r_data, 32'h0000_0001);
        csr_access(RD, 12'h340, 32'h0);
        check_val("post_rst_mscratch", r_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
